pipe_memory_stage: RTL and testbench

Memory stage plus M/W pipeline register for the pipelined Y86-64 core. It takes the EX/MEM register contents, performs the data-memory read or write, and computes the stage status. It latches results into the W register that feeds write-back, and exports combinational m_valM/m_stat for forwarding and hazard control. A sticky halt state machine blocks architectural memory updates once an exception or halt reaches write-back.

---
 rtl/pipe_memory_stage.sv | 176 +++++++++++++++++
 tb/tb_pipe_memory_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_memory_stage
//  Description : Y86-64 memory stage plus M/W pipeline register.
//                Performs the data-memory read (combinational) or 8-byte
//                big-endian write (posedge), computes the stage status,
//                latches results into the W register and keeps a sticky
//                halt state that freezes W and blocks memory updates once a
//                non-AOK status has reached write-back.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                M_stat..M_dstM           - EX/MEM register contents
//                W_stall, W_bubble        - W register pipeline control
//                m_valM, m_stat           - combinational read data / status
//                W_stat..W_dstM           - registered write-back inputs
//                halted                   - sticky halt indication
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_memory_stage #(
    parameter int           MEM_BYTES = 65536,
    parameter logic [3:0]   STAT_AOK  = 4'd1,
    parameter logic [3:0]   STAT_HLT  = 4'd2,
    parameter logic [3:0]   STAT_ADR  = 4'd3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      M_stat,
    input  logic [3:0]      M_icode,
    input  logic            M_cnd,
    input  logic [63:0]     M_valE,
    input  logic [63:0]     M_valA,
    input  logic [3:0]      M_dstE,
    input  logic [3:0]      M_dstM,
    input  logic            W_stall,
    input  logic            W_bubble,
    output logic [63:0]     m_valM,
    output logic [3:0]      m_stat,
    output logic [3:0]      W_stat,
    output logic [3:0]      W_icode,
    output logic            W_cnd,
    output logic [63:0]     W_valE,
    output logic [63:0]     W_valM,
    output logic [3:0]      W_dstE,
    output logic [3:0]      W_dstM,
    output logic            halted
);

    localparam int          c_AW        = $clog2(MEM_BYTES);
    localparam logic [63:0] c_MAX_ADDR  = 64'(MEM_BYTES - 8);

    localparam logic [3:0]  c_I_NOP     = 4'h1;
    localparam logic [3:0]  c_I_RMMOVQ  = 4'h4;
    localparam logic [3:0]  c_I_MRMOVQ  = 4'h5;
    localparam logic [3:0]  c_I_CALL    = 4'h8;
    localparam logic [3:0]  c_I_RET     = 4'h9;
    localparam logic [3:0]  c_I_PUSHQ   = 4'hA;
    localparam logic [3:0]  c_I_POPQ    = 4'hB;
    localparam logic [3:0]  c_R_NONE    = 4'hF;

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [7:0]         r_mem [0:MEM_BYTES-1];

    logic               w_is_read;
    logic               w_is_write;
    logic [63:0]        w_addr;
    logic               w_dmem_error;
    logic [c_AW-1:0]    w_idx [0:7];
    logic [63:0]        w_rdata;
    logic               w_do_write;
    logic               w_w_abnormal;

    // ------------------------------------------------------------------
    // Access decode and address select
    // ------------------------------------------------------------------
    always_comb begin
        w_is_read  = (M_icode == c_I_MRMOVQ) || (M_icode == c_I_POPQ) ||
                     (M_icode == c_I_RET);
        w_is_write = (M_icode == c_I_RMMOVQ) || (M_icode == c_I_PUSHQ) ||
                     (M_icode == c_I_CALL);
        // popq/ret read from the old stack pointer carried in valA.
        w_addr     = ((M_icode == c_I_POPQ) || (M_icode == c_I_RET)) ? M_valA : M_valE;
        // Unsigned 64-bit compare: no wrap-around, huge addresses fault.
        w_dmem_error = (w_is_read || w_is_write) && (w_addr > c_MAX_ADDR);
    end

    // Byte lane indices; only meaningful when the address is in range.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_idx[i] = w_addr[c_AW-1:0] + c_AW'(i);
        end
    end

    // Big-endian: lowest address holds the most significant byte.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            w_rdata[63-8*i -: 8] = r_mem[w_idx[i]];
        end
    end

    assign m_valM = (w_is_read && !w_dmem_error) ? w_rdata : 64'd0;
    assign m_stat = w_dmem_error ? STAT_ADR : M_stat;

    // ------------------------------------------------------------------
    // Data memory write: all eight bytes in one edge, gated by every
    // condition that could make the store non-architectural.
    // ------------------------------------------------------------------
    assign w_do_write = w_is_write && !w_dmem_error && (M_stat == STAT_AOK) &&
                        (W_stat == STAT_AOK) && (r_state == S_RUN) && !rst;

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[w_idx[i]] <= M_valA[63-8*i -: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Halt state machine
    // ------------------------------------------------------------------
    // HLT and ADR are the codes this stage passes or generates; any other
    // non-AOK code (e.g. an invalid instruction) stops the machine too.
    assign w_w_abnormal = (W_stat == STAT_HLT) || (W_stat == STAT_ADR) ||
                          (W_stat != STAT_AOK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:    if (w_w_abnormal) w_state_next = S_HALTED;
            S_HALTED: w_state_next = S_HALTED;
            default:  w_state_next = S_RUN;
        endcase
    end

    assign halted = (r_state == S_HALTED);

    // ------------------------------------------------------------------
    // W pipeline register: rst > halted hold > bubble > stall > load
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || (!halted && W_bubble)) begin
            W_stat  <= STAT_AOK;
            W_icode <= c_I_NOP;
            W_cnd   <= 1'b0;
            W_valE  <= 64'd0;
            W_valM  <= 64'd0;
            W_dstE  <= c_R_NONE;
            W_dstM  <= c_R_NONE;
        end else if (!halted && !W_stall) begin
            W_stat  <= m_stat;
            W_icode <= M_icode;
            W_cnd   <= M_cnd;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_memory_stage
//  Description : Self-checking bench for pipe_memory_stage. Vector table for
//                the main data path plus hand-written halt, address-fault
//                and reset sequences; W register results go through a queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
    logic        M_cnd;
    logic [63:0] M_valE, M_valA;
    logic        W_stall, W_bubble;
    logic [63:0] m_valM;
    logic [3:0]  m_stat;
    logic [3:0]  W_stat, W_icode, W_dstE, W_dstM;
    logic        W_cnd;
    logic [63:0] W_valE, W_valM;
    logic        halted;

    int total = 0;
    int bad   = 0;

    pipe_memory_stage dut (
        .clk      (clk),
        .rst      (rst),
        .M_stat   (M_stat),
        .M_icode  (M_icode),
        .M_cnd    (M_cnd),
        .M_valE   (M_valE),
        .M_valA   (M_valA),
        .M_dstE   (M_dstE),
        .M_dstM   (M_dstM),
        .W_stall  (W_stall),
        .W_bubble (W_bubble),
        .m_valM   (m_valM),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .W_icode  (W_icode),
        .W_cnd    (W_cnd),
        .W_valE   (W_valE),
        .W_valM   (W_valM),
        .W_dstE   (W_dstE),
        .W_dstM   (W_dstM),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic        stall;
        logic        bubble;
        logic [3:0]  exp_mstat;
        logic [63:0] exp_mvalM;
    } vec_t;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } wrec_t;

    localparam wrec_t NOP_W = '{stat: 4'd1, icode: 4'h1, cnd: 1'b0, valE: 64'd0,
                                valM: 64'd0, dstE: 4'hF, dstM: 4'hF};

    localparam logic [63:0] D1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] D2 = 64'hCAFEF00DDEADBEEF;
    localparam logic [63:0] D3 = 64'h1122334455667788;

    wrec_t  sb_q [$];
    wrec_t  mw;
    logic   mh;
    vec_t   tbl [13];

    function automatic vec_t mk(input logic r, input logic [3:0] st, input logic [3:0] ic,
                                input logic c, input logic [63:0] ve, input logic [63:0] va,
                                input logic [3:0] de, input logic [3:0] dm,
                                input logic s, input logic b,
                                input logic [3:0] ems, input logic [63:0] emv);
        vec_t v;
        v.rst = r; v.stat = st; v.icode = ic; v.cnd = c; v.valE = ve; v.valA = va;
        v.dstE = de; v.dstM = dm; v.stall = s; v.bubble = b;
        v.exp_mstat = ems; v.exp_mvalM = emv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input wrec_t act, input wrec_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of M inputs, check m_* combinationally, then check the
    // W register and halted state against the reference model after posedge.
    task automatic step(input vec_t v, input string name);
        wrec_t nxt;
        wrec_t got;
        wrec_t exp;
        logic  nh;
        @(negedge clk);
        rst = v.rst; M_stat = v.stat; M_icode = v.icode; M_cnd = v.cnd;
        M_valE = v.valE; M_valA = v.valA; M_dstE = v.dstE; M_dstM = v.dstM;
        W_stall = v.stall; W_bubble = v.bubble;
        #1;
        chk({name, " m_stat"}, 64'(m_stat), 64'(v.exp_mstat));
        chk({name, " m_valM"}, m_valM, v.exp_mvalM);
        if (v.rst)          nxt = NOP_W;
        else if (mh)        nxt = mw;
        else if (v.bubble)  nxt = NOP_W;
        else if (v.stall)   nxt = mw;
        else                nxt = '{stat: v.exp_mstat, icode: v.icode, cnd: v.cnd,
                                    valE: v.valE, valM: v.exp_mvalM,
                                    dstE: v.dstE, dstM: v.dstM};
        nh = !v.rst && (mh || (mw.stat != 4'd1));
        sb_q.push_back(nxt);
        mw = nxt;
        mh = nh;
        @(posedge clk);
        #1;
        got = '{stat: W_stat, icode: W_icode, cnd: W_cnd, valE: W_valE,
                valM: W_valM, dstE: W_dstE, dstM: W_dstM};
        exp = sb_q.pop_front();
        chk_w({name, " W"}, got, exp);
        chk({name, " halted"}, 64'(halted), 64'(mh));
    endtask

    task automatic do_reset(input string name);
        step(mk(1'b1, 4'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 4'd1, 64'd0), name);
    endtask

    initial begin
        rst = 1'b1; M_stat = 4'd1; M_icode = 4'h1; M_cnd = 1'b0;
        M_valE = 64'd0; M_valA = 64'd0; M_dstE = 4'hF; M_dstM = 4'hF;
        W_stall = 1'b0; W_bubble = 1'b0;
        mw = NOP_W; mh = 1'b0;

        for (int i = 0; i < 8; i++) begin
            dut.r_mem[16'h0300 + i] = D3[63-8*i -: 8];
            dut.r_mem[16'h0500 + i] = 8'h00;
        end
        dut.r_mem[16'h0200] = 8'hAA;

        // Reset held two cycles, then explicit field checks.
        do_reset("rst0");
        do_reset("rst1");
        chk("rst W_stat",  64'(W_stat),  64'd1);
        chk("rst W_icode", 64'(W_icode), 64'h1);
        chk("rst W_cnd",   64'(W_cnd),   64'd0);
        chk("rst W_valE",  W_valE,       64'd0);
        chk("rst W_valM",  W_valM,       64'd0);
        chk("rst W_dstE",  64'(W_dstE),  64'hF);
        chk("rst W_dstM",  64'(W_dstM),  64'hF);

        //         rst   stat  icode cnd   valE            valA      dstE  dstM  stl   bub   m_stat m_valM
        tbl[0]  = mk(1'b0, 4'd1, 4'h4, 1'b0, 64'h100,       D1,       4'hF, 4'hF, 1'b0, 1'b0, 4'd1, 64'd0);
        tbl[1]  = mk(1'b0, 4'd1, 4'h5, 1'b0, 64'h100,       64'd0,    4'hF, 4'h3, 1'b0, 1'b0, 4'd1, D1);
        tbl[2]  = mk(1'b0, 4'd1, 4'hB, 1'b0, 64'h108,       64'h300,  4'h4, 4'h5, 1'b0, 1'b0, 4'd1, D3);
        tbl[3]  = mk(1'b0, 4'd1, 4'h4, 1'b0, 64'hFFF8,      D2,       4'hF, 4'hF, 1'b0, 1'b0, 4'd1, 64'd0);
        tbl[4]  = mk(1'b0, 4'd1, 4'h5, 1'b0, 64'hFFF8,      64'd0,    4'hF, 4'h6, 1'b0, 1'b0, 4'd1, D2);
        tbl[5]  = mk(1'b0, 4'd1, 4'h6, 1'b1, 64'h42,        64'd5,    4'h2, 4'hF, 1'b0, 1'b0, 4'd1, 64'd0);
        tbl[6]  = mk(1'b0, 4'd1, 4'h5, 1'b0, 64'h100,       64'd0,    4'hF, 4'h7, 1'b1, 1'b0, 4'd1, D1);
        tbl[7]  = mk(1'b0, 4'd1, 4'h6, 1'b0, 64'h7,         64'd0,    4'h8, 4'hF, 1'b1, 1'b0, 4'd1, 64'd0);
        tbl[8]  = mk(1'b0, 4'd1, 4'h2, 1'b1, 64'h9,         64'd0,    4'h9, 4'hF, 1'b1, 1'b0, 4'd1, 64'd0);
        tbl[9]  = mk(1'b0, 4'd1, 4'h5, 1'b0, 64'h100,       64'd0,    4'hF, 4'h3, 1'b1, 1'b1, 4'd1, D1);
        tbl[10] = mk(1'b0, 4'd1, 4'h9, 1'b0, 64'h999,       64'h300,  4'h4, 4'hF, 1'b0, 1'b0, 4'd1, D3);
        tbl[11] = mk(1'b0, 4'd1, 4'h8, 1'b0, 64'h400,       64'h1234, 4'h4, 4'hF, 1'b0, 1'b0, 4'd1, 64'd0);
        tbl[12] = mk(1'b0, 4'd1, 4'h5, 1'b0, 64'h400,       64'd0,    4'hF, 4'h1, 1'b0, 1'b0, 4'd1, 64'h1234);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i], $sformatf("v%0d", i));
        end
        chk("mem[0x100]", 64'(dut.r_mem[16'h0100]), 64'h01);
        chk("mem[0x107]", 64'(dut.r_mem[16'h0107]), 64'hEF);
        chk("mem[0xFFFF]", 64'(dut.r_mem[16'hFFFF]), 64'hEF);

        // Halt reaches W; following pushes are blocked; W frozen under bubble.
        do_reset("h_rst");
        step(mk(1'b0, 4'd2, 4'h0, 1'b0, 64'd0,   64'd0,                 4'hF, 4'hF, 1'b0, 1'b0, 4'd2, 64'd0), "h_halt");
        step(mk(1'b0, 4'd1, 4'hA, 1'b0, 64'h200, 64'h5555555555555555, 4'h4, 4'hF, 1'b0, 1'b0, 4'd1, 64'd0), "h_push1");
        chk("h mem[0x200] a", 64'(dut.r_mem[16'h0200]), 64'hAA);
        step(mk(1'b0, 4'd1, 4'h5, 1'b0, 64'h300, 64'd0,                 4'hF, 4'h2, 1'b0, 1'b1, 4'd1, D3), "h_bubble");
        step(mk(1'b0, 4'd1, 4'hA, 1'b0, 64'h200, 64'h6666666666666666, 4'h4, 4'hF, 1'b0, 1'b0, 4'd1, 64'd0), "h_push2");
        chk("h mem[0x200] b", 64'(dut.r_mem[16'h0200]), 64'hAA);

        // Out-of-range accesses.
        do_reset("a_rst0");
        step(mk(1'b0, 4'd1, 4'h5, 1'b0, 64'hFFF9, 64'd0, 4'hF, 4'h3, 1'b0, 1'b0, 4'd3, 64'd0), "a_rd_fff9");
        do_reset("a_rst1");
        step(mk(1'b0, 4'd1, 4'h4, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h9999999999999999,
                4'hF, 4'hF, 1'b0, 1'b0, 4'd3, 64'd0), "a_wr_neg8");
        chk("a mem[0xFFF8]", 64'(dut.r_mem[16'hFFF8]), 64'hCA);
        chk("a mem[0xFFFF]", 64'(dut.r_mem[16'hFFFF]), 64'hEF);
        step(mk(1'b0, 4'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 4'd1, 64'd0), "a_nop");

        // Reset coinciding with a valid store.
        do_reset("r_rst");
        step(mk(1'b1, 4'd1, 4'h4, 1'b0, 64'h500, 64'h7777777777777777,
                4'hF, 4'hF, 1'b0, 1'b0, 4'd1, 64'd0), "r_rst_store");
        chk("r mem[0x500] a", 64'(dut.r_mem[16'h0500]), 64'h00);
        step(mk(1'b0, 4'd1, 4'h4, 1'b0, 64'h500, 64'h7777777777777777,
                4'hF, 4'hF, 1'b0, 1'b0, 4'd1, 64'd0), "r_store");
        chk("r mem[0x500] b", 64'(dut.r_mem[16'h0500]), 64'h77);
        chk("r mem[0x507] b", 64'(dut.r_mem[16'h0507]), 64'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
